// File: rtl/rd_cmd_sched_if.sv
// Handshake bundle between per-port dequeue logic, the memory read engine and
// the read-data destination stage, as seen by the read-command scheduler.
interface rd_cmd_sched_if #(
    parameter int unsigned NUM_PORT = 4,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned DATA_W   = 32
);
    logic [NUM_PORT-1:0]        iReqVld;
    logic [NUM_PORT-1:0]        oReqRdy;
    logic [NUM_PORT*ADDR_W-1:0] iReqAddr;
    logic [NUM_PORT*LEN_W-1:0]  iReqLen;
    logic [NUM_PORT-1:0]        iReqDrop;

    logic                       oCmdVld;
    logic                       iCmdRdy;
    logic [ADDR_W-1:0]          oCmdAddr;
    logic [LEN_W-1:0]           oCmdLen;
    logic [3:0]                 oCmdSrc;
    logic                       oCmdDrop;

    logic                       iDataVld;
    logic                       oDataRdy;
    logic [DATA_W-1:0]          iDataPld;
    logic                       iDataLast;
    logic [NUM_PORT-1:0]        oDataVld;
    logic [NUM_PORT-1:0]        iDataRdy;
    logic [DATA_W-1:0]          oDataPld;
    logic                       oDataLast;

    logic                       oBusy;
    logic                       oLenErr;

    modport slave (
        input  iReqVld, iReqAddr, iReqLen, iReqDrop,
        input  iCmdRdy,
        input  iDataVld, iDataPld, iDataLast, iDataRdy,
        output oReqRdy,
        output oCmdVld, oCmdAddr, oCmdLen, oCmdSrc, oCmdDrop,
        output oDataRdy, oDataVld, oDataPld, oDataLast,
        output oBusy, oLenErr
    );

    modport master (
        output iReqVld, iReqAddr, iReqLen, iReqDrop,
        output iCmdRdy,
        output iDataVld, iDataPld, iDataLast, iDataRdy,
        input  oReqRdy,
        input  oCmdVld, oCmdAddr, oCmdLen, oCmdSrc, oCmdDrop,
        input  oDataRdy, oDataVld, oDataPld, oDataLast,
        input  oBusy, oLenErr
    );
endinterface

// File: rtl/rd_cmd_sched.sv
// Round-robin read-command scheduler: grants one port, issues its command, then
// routes that burst's read data back to the granted port until the last beat.
module rd_cmd_sched #(
    parameter int unsigned NUM_PORT = 4,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned DATA_W   = 32
) (
    input  logic           iClk,
    input  logic           iRst_n,
    rd_cmd_sched_if.slave  bus
);
    localparam int unsigned IDX_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t             state,   stateNxt;
    logic [IDX_W-1:0]   rrPtr,   rrPtrNxt;
    logic [IDX_W-1:0]   gnt,     gntNxt;
    logic [ADDR_W-1:0]  cmdAddr, cmdAddrNxt;
    logic [LEN_W-1:0]   cmdLen,  cmdLenNxt;
    logic               cmdDrop, cmdDropNxt;
    logic [LEN_W-1:0]   beatCnt, beatCntNxt;

    logic               pickVld;
    logic [IDX_W-1:0]   pick;
    int unsigned        idx;
    logic [NUM_PORT-1:0] reqRdy;
    logic               lenErr;
    logic               inData;
    logic               beatAcc;

    // First requesting port at or after rrPtr, wrapping around.
    always_comb begin
        pickVld = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_PORT; i++) begin
            idx = (32'(rrPtr) + i) % NUM_PORT;
            if (!pickVld && bus.iReqVld[idx]) begin
                pickVld = 1'b1;
                pick    = IDX_W'(idx);
            end
        end
    end

    assign inData  = (state == DATA);
    assign beatAcc = inData && bus.iDataVld && bus.iDataRdy[gnt];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state   <= IDLE;
            rrPtr   <= '0;
            gnt     <= '0;
            cmdAddr <= '0;
            cmdLen  <= '0;
            cmdDrop <= 1'b0;
            beatCnt <= '0;
        end else begin
            state   <= stateNxt;
            rrPtr   <= rrPtrNxt;
            gnt     <= gntNxt;
            cmdAddr <= cmdAddrNxt;
            cmdLen  <= cmdLenNxt;
            cmdDrop <= cmdDropNxt;
            beatCnt <= beatCntNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        rrPtrNxt   = rrPtr;
        gntNxt     = gnt;
        cmdAddrNxt = cmdAddr;
        cmdLenNxt  = cmdLen;
        cmdDropNxt = cmdDrop;
        beatCntNxt = beatCnt;
        reqRdy     = '0;
        lenErr     = 1'b0;
        case (state)
            IDLE: begin
                if (pickVld) begin
                    reqRdy[pick] = 1'b1;
                    gntNxt       = pick;
                    cmdAddrNxt   = bus.iReqAddr[32'(pick)*ADDR_W +: ADDR_W];
                    cmdLenNxt    = bus.iReqLen[32'(pick)*LEN_W +: LEN_W];
                    cmdDropNxt   = bus.iReqDrop[pick];
                    rrPtrNxt     = (32'(pick) == NUM_PORT - 1) ? '0 : IDX_W'(pick + IDX_W'(1));
                    stateNxt     = CMD;
                end
            end
            CMD: begin
                if (bus.iCmdRdy) begin
                    if (cmdDrop) begin
                        stateNxt = IDLE;
                    end else begin
                        beatCntNxt = '0;
                        stateNxt   = DATA;
                    end
                end
            end
            DATA: begin
                if (beatAcc) begin
                    if (beatCnt != '1) beatCntNxt = beatCnt + LEN_W'(1);
                    // Early last and overrun both flag; overrun keeps waiting for last.
                    if (bus.iDataLast) begin
                        stateNxt = IDLE;
                        lenErr   = (beatCnt != cmdLen);
                    end else begin
                        lenErr   = (beatCnt == cmdLen);
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign bus.oReqRdy   = reqRdy;
    assign bus.oCmdVld   = (state == CMD);
    assign bus.oCmdAddr  = cmdAddr;
    assign bus.oCmdLen   = cmdLen;
    assign bus.oCmdSrc   = 4'(gnt);
    assign bus.oCmdDrop  = cmdDrop;
    assign bus.oDataRdy  = inData && bus.iDataRdy[gnt];
    assign bus.oDataVld  = (inData && bus.iDataVld) ? (NUM_PORT'(1) << gnt) : '0;
    assign bus.oDataPld  = bus.iDataPld;
    assign bus.oDataLast = bus.iDataLast;
    assign bus.oBusy     = (state != IDLE);
    assign bus.oLenErr   = lenErr;
endmodule

// File: tb/tb_rd_cmd_sched.sv
// Directed bench for rd_cmd_sched: arbitration order, drop path, command stall,
// length errors, data back-pressure and asynchronous reset mid-burst.
module tb_rd_cmd_sched;
    localparam int unsigned NUM_PORT = 4;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned DATA_W   = 32;

    logic iClk;
    logic iRst_n;
    int   nChk;
    int   nErr;

    rd_cmd_sched_if #(.NUM_PORT(NUM_PORT), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

    rd_cmd_sched #(.NUM_PORT(NUM_PORT), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChk++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic setPort(input int p, input logic [15:0] a, input logic [7:0] l, input logic d);
        bus.iReqAddr[p*ADDR_W +: ADDR_W] = a;
        bus.iReqLen[p*LEN_W +: LEN_W]    = l;
        bus.iReqDrop[p]                  = d;
    endtask

    initial begin
        nChk = 0;
        nErr = 0;
        iRst_n        = 1'b0;
        bus.iReqVld   = '0;
        bus.iReqAddr  = '0;
        bus.iReqLen   = '0;
        bus.iReqDrop  = '0;
        bus.iCmdRdy   = 1'b0;
        bus.iDataVld  = 1'b0;
        bus.iDataPld  = 32'hA5A5_0000;
        bus.iDataLast = 1'b0;
        bus.iDataRdy  = '0;

        // Reset state
        #2;
        chk("rst_outs", 64'({bus.oReqRdy, bus.oCmdVld, bus.oBusy, bus.oDataVld, bus.oDataRdy, bus.oLenErr}), 64'(0));
        chk("rst_cmd", 64'({bus.oCmdSrc, bus.oCmdAddr, bus.oCmdLen, bus.oCmdDrop}), 64'(0));
        chk("rst_pld", 64'(bus.oDataPld), 64'(32'hA5A5_0000));
        #20 iRst_n = 1'b1;
        cyc();

        // Single port 1 burst of 4 beats
        setPort(1, 16'h0040, 8'd3, 1'b0);
        bus.iReqVld = 4'b0010;
        settle();
        chk("t1_reqRdy", 64'({bus.oReqRdy, bus.oCmdVld}), 64'({4'b0010, 1'b0}));
        cyc();
        bus.iReqVld = '0;
        bus.iCmdRdy = 1'b1;
        settle();
        chk("t1_cmd", 64'({bus.oCmdVld, bus.oCmdSrc, bus.oCmdAddr, bus.oCmdLen, bus.oCmdDrop, bus.oReqRdy}),
            64'({1'b1, 4'd1, 16'h0040, 8'd3, 1'b0, 4'b0000}));
        cyc();
        bus.iCmdRdy  = 1'b0;
        bus.iDataVld = 1'b1;
        bus.iDataRdy = 4'hF;
        for (int b = 0; b < 4; b++) begin
            bus.iDataLast = (b == 3);
            bus.iDataPld  = 32'hD000_0000 + 32'(b);
            settle();
            chk("t1_beat", 64'({bus.oDataVld, bus.oDataRdy, bus.oLenErr, bus.oBusy}), 64'({4'b0010, 1'b1, 1'b0, 1'b1}));
            chk("t1_pass", 64'({bus.oDataPld, bus.oDataLast}), 64'({32'hD000_0000 + 32'(b), 1'(b == 3)}));
            cyc();
        end
        bus.iDataVld  = 1'b0;
        bus.iDataLast = 1'b0;
        settle();
        chk("t1_idle", 64'({bus.oBusy, bus.oLenErr}), 64'(0));

        // Async reset mid-burst
        setPort(0, 16'h0100, 8'd7, 1'b0);
        bus.iReqVld = 4'b0001;
        settle();
        chk("rs_reqRdy", 64'(bus.oReqRdy), 64'(4'b0001));
        cyc();
        bus.iReqVld = '0;
        bus.iCmdRdy = 1'b1;
        cyc();
        bus.iCmdRdy  = 1'b0;
        bus.iDataVld = 1'b1;
        settle();
        chk("rs_data", 64'({bus.oDataVld, bus.oBusy}), 64'({4'b0001, 1'b1}));
        cyc();
        iRst_n = 1'b0;
        settle();
        chk("rs_zero", 64'({bus.oBusy, bus.oCmdVld, bus.oDataVld, bus.oDataRdy, bus.oLenErr, bus.oReqRdy}), 64'(0));
        bus.iDataVld = 1'b0;
        #2 iRst_n = 1'b1;
        cyc();

        // All ports, len 0, continuous: grants 0,1,2,3,0 every 3 cycles
        for (int p = 0; p < 4; p++) setPort(p, 16'(p * 256), 8'd0, 1'b0);
        bus.iReqVld   = 4'hF;
        bus.iCmdRdy   = 1'b1;
        bus.iDataVld  = 1'b1;
        bus.iDataLast = 1'b1;
        bus.iDataRdy  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            settle();
            chk("rr_idle", 64'({bus.oReqRdy, bus.oDataVld, bus.oDataRdy, bus.oBusy}),
                64'({4'(1 << g), 4'b0000, 1'b0, 1'b0}));
            cyc();
            settle();
            chk("rr_cmd", 64'({bus.oCmdVld, bus.oCmdSrc, bus.oCmdAddr, bus.oReqRdy}),
                64'({1'b1, 4'(g), 16'(g * 256), 4'b0000}));
            cyc();
            settle();
            chk("rr_data", 64'({bus.oDataVld, bus.oDataRdy, bus.oLenErr}), 64'({4'(1 << g), 1'b1, 1'b0}));
            cyc();
        end
        bus.iReqVld   = '0;
        bus.iDataVld  = 1'b0;
        bus.iDataLast = 1'b0;

        // Port 2 drop while port 3 pending
        setPort(2, 16'h2200, 8'd0, 1'b1);
        setPort(3, 16'h3300, 8'd0, 1'b0);
        bus.iReqVld = 4'b1100;
        settle();
        chk("dr_reqRdy", 64'(bus.oReqRdy), 64'(4'b0100));
        cyc();
        bus.iReqVld = 4'b1000;
        settle();
        chk("dr_cmd", 64'({bus.oCmdVld, bus.oCmdDrop, bus.oCmdSrc, bus.oCmdAddr, bus.oReqRdy}),
            64'({1'b1, 1'b1, 4'd2, 16'h2200, 4'b0000}));
        cyc();
        bus.iDataVld  = 1'b1;
        bus.iDataLast = 1'b1;
        settle();
        chk("dr_next", 64'({bus.oBusy, bus.oReqRdy, bus.oDataVld, bus.oDataRdy}), 64'({1'b0, 4'b1000, 4'b0000, 1'b0}));
        cyc();
        bus.iReqVld = '0;
        settle();
        chk("dr_cmd3", 64'({bus.oCmdVld, bus.oCmdDrop, bus.oCmdSrc}), 64'({1'b1, 1'b0, 4'd3}));
        cyc();
        settle();
        chk("dr_data3", 64'(bus.oDataVld), 64'(4'b1000));
        cyc();
        bus.iDataVld  = 1'b0;
        bus.iDataLast = 1'b0;
        bus.iCmdRdy   = 1'b0;

        // Command stalled 5 cycles while port 1 waits
        setPort(0, 16'h1234, 8'd3, 1'b0);
        setPort(1, 16'h5678, 8'd1, 1'b0);
        bus.iReqVld = 4'b0011;
        settle();
        chk("st_reqRdy", 64'(bus.oReqRdy), 64'(4'b0001));
        cyc();
        bus.iReqVld = 4'b0010;
        for (int s = 0; s < 5; s++) begin
            settle();
            chk("st_hold", 64'({bus.oCmdVld, bus.oCmdAddr, bus.oCmdLen, bus.oCmdSrc, bus.oReqRdy}),
                64'({1'b1, 16'h1234, 8'd3, 4'd0, 4'b0000}));
            cyc();
        end
        bus.iCmdRdy = 1'b1;
        cyc();
        bus.iCmdRdy = 1'b0;

        // len 3, last on beat 2: early-last error
        bus.iDataVld  = 1'b1;
        bus.iDataLast = 1'b0;
        settle();
        chk("le_b1", 64'({bus.oDataVld, bus.oLenErr}), 64'({4'b0001, 1'b0}));
        cyc();
        bus.iDataLast = 1'b1;
        settle();
        chk("le_b2", 64'({bus.oDataVld, bus.oLenErr}), 64'({4'b0001, 1'b1}));
        cyc();
        bus.iDataVld  = 1'b0;
        bus.iDataLast = 1'b0;
        settle();
        chk("le_idle", 64'({bus.oBusy, bus.oLenErr, bus.oReqRdy}), 64'({1'b0, 1'b0, 4'b0010}));
        cyc();
        bus.iReqVld = '0;
        bus.iCmdRdy = 1'b1;
        settle();
        chk("ov_cmd", 64'({bus.oCmdVld, bus.oCmdSrc, bus.oCmdLen}), 64'({1'b1, 4'd1, 8'd1}));
        cyc();
        bus.iCmdRdy = 1'b0;

        // len 1, stall mid-burst, overrun then last on beat 3
        bus.iDataVld = 1'b1;
        bus.iDataRdy = 4'hF;
        settle();
        chk("ov_b1", 64'({bus.oDataVld, bus.oDataRdy, bus.oLenErr}), 64'({4'b0010, 1'b1, 1'b0}));
        cyc();
        bus.iDataRdy = 4'b1101;
        settle();
        chk("ov_stall", 64'({bus.oDataVld, bus.oDataRdy, bus.oLenErr}), 64'({4'b0010, 1'b0, 1'b0}));
        cyc();
        bus.iDataRdy = 4'hF;
        settle();
        chk("ov_b2", 64'({bus.oDataVld, bus.oDataRdy, bus.oLenErr}), 64'({4'b0010, 1'b1, 1'b1}));
        cyc();
        bus.iDataLast = 1'b1;
        settle();
        chk("ov_b3", 64'({bus.oDataVld, bus.oLenErr, bus.oBusy}), 64'({4'b0010, 1'b1, 1'b1}));
        cyc();
        bus.iDataVld  = 1'b0;
        bus.iDataLast = 1'b0;
        settle();
        chk("ov_idle", 64'({bus.oBusy, bus.oLenErr, bus.oDataRdy}), 64'(0));

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end
endmodule
